data_memory_unit: RTL and testbench

//   Parametrised data memory for the lab CPU datapath: DEPTH = 2**ADDR_W words of DATA_W bits.

---
 rtl/data_memory_unit.sv | 89 ++++++++
 tb/tb_data_memory_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// Data memory for the lab CPU datapath: LOAD / STORE / LOAD-ADDRESS under valid/ready,
// with a hardware fill of the whole array after every reset.
module data_memory_unit #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] ra,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic              init_done
);
  localparam int DEPTH = 2**ADDR_W;

  localparam logic [3:0] OP_LOAD  = 4'd13;
  localparam logic [3:0] OP_STORE = 4'd14;
  localparam logic [3:0] OP_LDA   = 4'd15;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fill_ptr;
  logic [DATA_W-1:0] fill_word;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              is_load, is_store, is_lda;

  assign is_load  = (op == OP_LOAD);
  assign is_store = (op == OP_STORE);
  assign is_lda   = (op == OP_LDA);

  // Both flags are pure functions of the state: they rise on the edge that ends the fill
  // and only fall again through rst.
  assign req_ready = (state == RUN);
  assign init_done = (state == RUN);

  // Next state, request acceptance and fill pattern.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fill_word = '0;
    case (state)
      INIT: if (fill_ptr == '1) state_nxt = RUN;
      RUN:  accept = req_valid;
      default: state_nxt = INIT;
    endcase
    // Index cast to the word width: truncates or zero-extends as needed.
    if (INIT_MODE == 1) fill_word = DATA_W'(fill_ptr);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Fill pointer; wraps to 0 on the last fill write and is then left alone.
  always_ff @(posedge clk) begin
    if (rst)                fill_ptr <= '0;
    else if (state == INIT) fill_ptr <= fill_ptr + 1'b1;
  end

  // Array writes: fill during INIT, stores during RUN. Nothing is written on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)          mem[fill_ptr] <= fill_word;
      else if (accept && is_store) mem[address] <= ra;
    end
  end

  // Read result and its one-cycle valid; reads see the array before this edge's store,
  // so a load followed by a store to the same word returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= accept && (is_load || is_lda);
      if (accept && is_load)     read_data <= mem[address];
      else if (accept && is_lda) read_data <= DATA_W'(address);
    end
  end
endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench for data_memory_unit: default 8x256 instance plus a 4-bit x 64 instance,
// directed scenarios and randomized traffic against an array-based reference model.
module tb_data_memory_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DATA_W=8, ADDR_W=8
  logic       a_rst = 1'b1, a_v = 1'b0, a_rdy, a_rdv, a_done;
  logic [3:0] a_op = '0;
  logic [7:0] a_addr = '0, a_ra = '0, a_rdata;
  // Instance B: DATA_W=4, ADDR_W=6
  logic       b_rst = 1'b1, b_v = 1'b0, b_rdy, b_rdv, b_done;
  logic [3:0] b_op = '0;
  logic [5:0] b_addr = '0;
  logic [3:0] b_ra = '0, b_rdata;

  data_memory_unit #(.DATA_W(8), .ADDR_W(8), .INIT_MODE(1)) dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_v), .req_ready(a_rdy), .op(a_op),
    .address(a_addr), .ra(a_ra), .read_data(a_rdata), .rd_valid(a_rdv), .init_done(a_done));

  data_memory_unit #(.DATA_W(4), .ADDR_W(6), .INIT_MODE(1)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_v), .req_ready(b_rdy), .op(b_op),
    .address(b_addr), .ra(b_ra), .read_data(b_rdata), .rd_valid(b_rdv), .init_done(b_done));

  int tests_run = 0, tests_failed = 0;

  // Reference model: per unit, the word array, last result, valid pulse and init countdown.
  int mm [2][256];
  int rd_m [2];
  bit rdv_m [2];
  int busy [2];

  function automatic int dw_of(int u);  return (u == 0) ? 8 : 4;   endfunction
  function automatic int dep_of(int u); return (u == 0) ? 256 : 64; endfunction

  task automatic model_edge(int u, bit rs, bit v, int op, int addr, int ra);
    int mask = (1 << dw_of(u)) - 1;
    if (rs) begin
      busy[u] = dep_of(u); rdv_m[u] = 0; rd_m[u] = 0;
      for (int i = 0; i < dep_of(u); i++) mm[u][i] = i & mask;
    end else if (busy[u] > 0) begin
      busy[u]--; rdv_m[u] = 0;
    end else begin
      rdv_m[u] = v && (op == 13 || op == 15);
      if (v) begin
        if (op == 13) rd_m[u] = mm[u][addr];
        if (op == 14) mm[u][addr] = ra & mask;
        if (op == 15) rd_m[u] = addr & mask;
      end
    end
  endtask

  // One clock: inputs held across the rising edge, outputs sampled on the falling edge.
  task automatic step();
    bit ar = a_rst, av = a_v, br = b_rst, bv = b_v;
    int aop = int'(a_op), aad = int'(a_addr), ara = int'(a_ra);
    int bop = int'(b_op), bad = int'(b_addr), bra = int'(b_ra);
    @(posedge clk);
    model_edge(0, ar, av, aop, aad, ara);
    model_edge(1, br, bv, bop, bad, bra);
    @(negedge clk);
  endtask

  task automatic drv_a(bit v, int op, int addr, int ra);
    a_v = v; a_op = 4'(op); a_addr = 8'(addr); a_ra = 8'(ra);
  endtask

  task automatic drv_b(bit v, int op, int addr, int ra);
    b_v = v; b_op = 4'(op); b_addr = 6'(addr); b_ra = 4'(ra);
  endtask

  task automatic test_reset();
    int n = 0;
    a_rst = 1; step(); a_rst = 0;
    tests_run++;
    if (a_rdy !== 1'b0 || a_done !== 1'b0 || a_rdv !== 1'b0 || a_rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_state: rdy=%b done=%b rdv=%b rdata=%h want 0 0 0 00", a_rdy, a_done, a_rdv, a_rdata);
    end
    while (a_rdy !== 1'b1 && n < 400) begin drv_a(1, 13, n, 0); step(); n++; end
    drv_a(0, 0, 0, 0);
    tests_run++;
    if (n != 256) begin tests_failed++; $display("FAIL init_len: got %0d cycles want 256", n); end
    tests_run++;
    if (a_done !== 1'b1) begin tests_failed++; $display("FAIL init_done: got %b want 1", a_done); end
  endtask

  task automatic test_load();
    drv_a(1, 13, 8'h2A, 0); step(); drv_a(0, 0, 0, 0);
    tests_run++;
    if (a_rdv !== 1'b1 || a_rdata !== 8'h2A) begin
      tests_failed++; $display("FAIL load_2a: rdv=%b rdata=%h want 1 2a", a_rdv, a_rdata);
    end
    step();
    tests_run++;
    if (a_rdv !== 1'b0 || a_rdata !== 8'h2A) begin
      tests_failed++; $display("FAIL load_2a_after: rdv=%b rdata=%h want 0 2a", a_rdv, a_rdata);
    end
  endtask

  task automatic test_store_load();
    drv_a(1, 14, 8'h10, 8'hC3); step();
    tests_run++;
    if (a_rdv !== 1'b0) begin tests_failed++; $display("FAIL store_rdv: got %b want 0", a_rdv); end
    drv_a(1, 13, 8'h10, 0); step();
    tests_run++;
    if (a_rdv !== 1'b1 || a_rdata !== 8'hC3) begin
      tests_failed++; $display("FAIL store_then_load: rdv=%b rdata=%h want 1 c3", a_rdv, a_rdata);
    end
    drv_a(1, 13, 8'h11, 0); step();
    tests_run++;
    if (a_rdata !== 8'h11) begin tests_failed++; $display("FAIL load_11: got %h want 11", a_rdata); end
    // Load then store of the same word: load sees the old contents.
    drv_a(1, 13, 8'h20, 0); step();
    drv_a(1, 14, 8'h20, 8'h99); step();
    tests_run++;
    if (a_rdata !== 8'h20) begin tests_failed++; $display("FAIL load_before_store: got %h want 20", a_rdata); end
    drv_a(1, 13, 8'h20, 0); step(); drv_a(0, 0, 0, 0);
    tests_run++;
    if (a_rdata !== 8'h99) begin tests_failed++; $display("FAIL load_after_store: got %h want 99", a_rdata); end
  endtask

  task automatic test_load_addr();
    drv_a(1, 15, 8'h7F, 0); step();
    tests_run++;
    if (a_rdv !== 1'b1 || a_rdata !== 8'h7F) begin
      tests_failed++; $display("FAIL lda_7f: rdv=%b rdata=%h want 1 7f", a_rdv, a_rdata);
    end
    drv_a(1, 3, 8'h05, 8'hEE); step(); drv_a(0, 0, 0, 0);
    tests_run++;
    if (a_rdv !== 1'b0 || a_rdata !== 8'h7F) begin
      tests_failed++; $display("FAIL nop_hold: rdv=%b rdata=%h want 0 7f", a_rdv, a_rdata);
    end
    drv_a(1, 13, 8'h05, 0); step(); drv_a(0, 0, 0, 0);
    tests_run++;
    if (a_rdata !== 8'h05) begin tests_failed++; $display("FAIL nop_no_write: got %h want 05", a_rdata); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      int ad = $urandom_range(0, 255);
      drv_a(1, (i % 3 == 2) ? 15 : 13, ad, 0); step();
      tests_run++;
      if (a_rdv !== 1'b1 || int'(a_rdata) != rd_m[0]) begin
        tests_failed++;
        $display("FAIL b2b_%0d: rdv=%b rdata=%h want 1 %h", i, a_rdv, a_rdata, rd_m[0]);
      end
    end
    drv_a(0, 0, 0, 0);
  endtask

  task automatic test_random(int u, int cycles);
    for (int i = 0; i < cycles; i++) begin
      bit v = 1'($urandom_range(0, 1));
      int op = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(13, 15);
      int ad = $urandom_range(0, dep_of(u) - 1);
      int ra = $urandom_range(0, (1 << dw_of(u)) - 1);
      int g_rd;
      bit g_rdv, g_rdy;
      if (u == 0) drv_a(v, op, ad, ra); else drv_b(v, op, ad, ra);
      step();
      g_rd  = (u == 0) ? int'(a_rdata) : int'(b_rdata);
      g_rdv = (u == 0) ? a_rdv : b_rdv;
      g_rdy = (u == 0) ? a_rdy : b_rdy;
      tests_run++;
      if (g_rdv !== rdv_m[u] || g_rd != rd_m[u] || g_rdy !== (busy[u] == 0)) begin
        tests_failed++;
        $display("FAIL rand_u%0d_c%0d: rdv=%b rd=%h rdy=%b want %b %h %b",
                 u, i, g_rdv, g_rd, g_rdy, rdv_m[u], rd_m[u], busy[u] == 0);
      end
    end
    if (u == 0) drv_a(0, 0, 0, 0); else drv_b(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int n = 0, bad = 0;
    drv_a(1, 14, 8'h10, 8'h55); step(); drv_a(0, 0, 0, 0);
    a_rst = 1; step(); a_rst = 0;
    for (int i = 0; i < 50; i++) begin drv_a(1, 14, 8'h10, 8'hAA); step(); end
    a_rst = 1; step(); a_rst = 0;
    while (a_rdy !== 1'b1 && n < 400) begin
      drv_a(1, $urandom_range(13, 15), 8'h10, $urandom_range(0, 255));
      step(); n++;
      if (a_rdv !== 1'b0 || a_rdata !== 8'h00) bad++;
    end
    drv_a(0, 0, 0, 0);
    tests_run++;
    if (n != 256) begin tests_failed++; $display("FAIL reinit_len: got %0d cycles want 256", n); end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL init_ignores_req: got %0d bad cycles want 0", bad); end
    drv_a(1, 13, 8'h10, 0); step(); drv_a(0, 0, 0, 0);
    tests_run++;
    if (a_rdv !== 1'b1 || a_rdata !== 8'h10) begin
      tests_failed++; $display("FAIL store_wiped: rdv=%b rdata=%h want 1 10", a_rdv, a_rdata);
    end
  endtask

  task automatic test_narrow();
    int n = 0;
    b_rst = 1; step(); b_rst = 0;
    while (b_rdy !== 1'b1 && n < 200) begin step(); n++; end
    tests_run++;
    if (n != 64 || b_done !== 1'b1) begin
      tests_failed++; $display("FAIL narrow_init: got %0d cycles done=%b want 64 1", n, b_done);
    end
    drv_b(1, 13, 6'h23, 0); step();
    tests_run++;
    if (b_rdv !== 1'b1 || b_rdata !== 4'h3) begin
      tests_failed++; $display("FAIL narrow_load_23: rdv=%b rdata=%h want 1 3", b_rdv, b_rdata);
    end
    drv_b(1, 15, 6'h2F, 0); step(); drv_b(0, 0, 0, 0);
    tests_run++;
    if (b_rdv !== 1'b1 || b_rdata !== 4'hF) begin
      tests_failed++; $display("FAIL narrow_lda_2f: rdv=%b rdata=%h want 1 f", b_rdv, b_rdata);
    end
    test_random(1, 200);
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_load();
    test_load_addr();
    test_back_to_back();
    test_random(0, 400);
    test_reset_mid();
    test_narrow();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
